// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_seq_pkg
//  Description : Shared types and default widths for the PC sequencer slice.
//                Holds the sequencer state encoding and the decoder redirect
//                type encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package pc_seq_pkg;

  localparam int PC_W_DEFAULT  = 16;
  localparam int OFF_W_DEFAULT = 9;

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2,
    S_HALT   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    BR_REL  = 2'b00,
    BR_JUMP = 2'b01,
    BR_CALL = 2'b10,
    BR_RET  = 2'b11
  } br_type_e;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer_if
//  Description : Bundle of every sequencer signal except clock and reset.
//                master : sequencer side (drives PC controls, fetch request,
//                         status flags)
//                slave  : environment side (PC value, memory ack, decoder
//                         redirect requests, irq, halt)
//  Revision    : 1.0  initial release
// ============================================================================
interface pc_sequencer_if
  import pc_seq_pkg::*;
#(
  parameter int PC_W  = PC_W_DEFAULT,
  parameter int OFF_W = OFF_W_DEFAULT
);

  // ProgramCounter control
  logic [PC_W-1:0]  pc_in;
  logic             load_enable;
  logic [PC_W-1:0]  load_value;
  logic             offset_enable;
  logic [OFF_W-1:0] offset;

  // Instruction fetch handshake
  logic             imem_req;
  logic             imem_ack;
  logic             fetch_valid;

  // Decoder redirect request
  logic             br_valid;
  br_type_e         br_type;
  logic             br_taken;
  logic [OFF_W-1:0] br_offset;
  logic [PC_W-1:0]  br_target;

  // Interrupt / halt / status
  logic             irq;
  logic             irq_ack;
  logic             halt;
  logic             halted;
  logic             stack_err;

  modport master (
    input  pc_in, imem_ack, br_valid, br_type, br_taken, br_offset,
           br_target, irq, halt,
    output load_enable, load_value, offset_enable, offset, imem_req,
           fetch_valid, irq_ack, halted, stack_err
  );

  modport slave (
    output pc_in, imem_ack, br_valid, br_type, br_taken, br_offset,
           br_target, irq, halt,
    input  load_enable, load_value, offset_enable, offset, imem_req,
           fetch_valid, irq_ack, halted, stack_err
  );

endinterface
`default_nettype wire

// File: rtl/pc_sequencer_ret_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ret_stack
//  Description : Return-address LIFO, DEPTH entries of W bits.
//                push_i  : write wdata_i on top (ignored when full)
//                pop_i   : drop top entry (ignored when empty)
//                rdata_o : current top entry (undefined when empty)
//                full_o / empty_o : occupancy flags
//                Asynchronous reset empties the stack.
//  Revision    : 1.0  initial release
// ============================================================================
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         push_i,
  input  wire logic         pop_i,
  input  wire logic [W-1:0] wdata_i,
  output logic      [W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SP_W-1:0] sp_q, sp_d;
  logic [W-1:0]    mem_q [DEPTH];
  logic            w_do_push;
  logic            w_do_pop;

  assign full_o  = (sp_q == SP_W'(DEPTH));
  assign empty_o = (sp_q == '0);

  // A simultaneous push/pop is never issued by the sequencer; push wins.
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o && !push_i;

  // sp_q points one past the top entry.
  assign rdata_o = mem_q[IDX_W'(sp_q - 1'b1)];

  always_comb begin
    sp_d = sp_q;
    if (w_do_push) begin
      sp_d = sp_q + 1'b1;
    end else if (w_do_pop) begin
      sp_d = sp_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Storage needs no reset: entries are only readable after being pushed.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[IDX_W'(sp_q)] <= wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Fetch/redirect controller for a free-running ProgramCounter.
//                The PC increments every cycle unless loaded, so every "hold"
//                is a reload of pc_in. Handles the fetch handshake, relative
//                branches, jumps, call/return via ret_stack, one level of
//                interrupt, and halt.
//  Ports       : clk, rst (async, active-high)
//                bus (pc_sequencer_if.master) : PC controls, fetch handshake,
//                decoder redirect, irq/halt and status flags
//  Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W         = PC_W_DEFAULT,
  parameter int              OFF_W        = OFF_W_DEFAULT,
  parameter int              STACK_DEPTH  = 4,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0,
  parameter logic [PC_W-1:0] IRQ_VECTOR   = PC_W'('h10)
) (
  input  wire logic      clk,
  input  wire logic      rst,
  pc_sequencer_if.master bus
);

  state_e           state_q, state_d;
  logic             irq_active_q, irq_active_d;
  logic             stack_err_q, stack_err_d;
  logic             halted_q;

  logic             w_load_en;
  logic [PC_W-1:0]  w_load_val;
  logic             w_off_en;
  logic [OFF_W-1:0] w_offset;
  logic             w_imem_req;
  logic             w_fetch_vld;
  logic             w_irq_ack;
  logic             w_push;
  logic             w_pop;
  logic [PC_W-1:0]  w_rdata;
  logic             w_full;
  logic             w_empty;

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_ret_stack (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (bus.pc_in),
    .rdata_o (w_rdata),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_comb begin
    state_d      = state_q;
    irq_active_d = irq_active_q;
    stack_err_d  = stack_err_q;
    w_load_en    = 1'b1;
    w_load_val   = bus.pc_in;
    w_off_en     = 1'b0;
    w_offset     = '0;
    w_imem_req   = 1'b0;
    w_fetch_vld  = 1'b0;
    w_irq_ack    = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;

    case (state_q)
      S_BOOT: begin
        w_load_val = RESET_VECTOR;
        state_d    = S_FETCH;
      end

      S_FETCH: begin
        w_imem_req = 1'b1;
        if (bus.imem_ack) begin
          // Let the PC count so DECODE sees fetched address + 1.
          w_load_en   = 1'b0;
          w_fetch_vld = 1'b1;
          state_d     = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = S_FETCH;
        if (bus.halt) begin
          state_d = S_HALT;
        end else if (bus.br_valid) begin
          // A coincident irq is simply not looked at; it stays pending.
          case (bus.br_type)
            BR_REL: begin
              if (bus.br_taken) begin
                w_load_en = 1'b0;
                w_off_en  = 1'b1;
                w_offset  = bus.br_offset;
              end
            end
            BR_JUMP: begin
              w_load_val = bus.br_target;
            end
            BR_CALL: begin
              w_load_val = bus.br_target;
              if (w_full) begin
                stack_err_d = 1'b1;
              end else begin
                w_push = 1'b1;
              end
            end
            BR_RET: begin
              if (w_empty) begin
                stack_err_d = 1'b1;
              end else begin
                w_pop        = 1'b1;
                w_load_val   = w_rdata;
                irq_active_d = 1'b0;
              end
            end
            default: ;
          endcase
        end else if (bus.irq && !irq_active_q) begin
          w_load_val   = IRQ_VECTOR;
          w_irq_ack    = 1'b1;
          irq_active_d = 1'b1;
          if (w_full) begin
            stack_err_d = 1'b1;
          end else begin
            w_push = 1'b1;
          end
        end
      end

      S_HALT: ;

      default: state_d = S_BOOT;
    endcase

    // Control outputs are held inactive for the whole reset pulse.
    if (rst) begin
      w_load_en   = 1'b0;
      w_load_val  = '0;
      w_off_en    = 1'b0;
      w_offset    = '0;
      w_imem_req  = 1'b0;
      w_fetch_vld = 1'b0;
      w_irq_ack   = 1'b0;
      w_push      = 1'b0;
      w_pop       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_BOOT;
      irq_active_q <= 1'b0;
      stack_err_q  <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      irq_active_q <= irq_active_d;
      stack_err_q  <= stack_err_d;
      halted_q     <= (state_d == S_HALT);
    end
  end

  assign bus.load_enable   = w_load_en;
  assign bus.load_value    = w_load_val;
  assign bus.offset_enable = w_off_en;
  assign bus.offset        = w_offset;
  assign bus.imem_req      = w_imem_req;
  assign bus.fetch_valid   = w_fetch_vld;
  assign bus.irq_ack       = w_irq_ack;
  assign bus.halted        = halted_q;
  assign bus.stack_err     = stack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Testbench for pc_sequencer. Models the ProgramCounter,
//                queues the expected address of every fetch as redirects are
//                driven, and compares each accepted fetch against the queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic clk;
  logic rst;

  pc_sequencer_if #(.PC_W(16), .OFF_W(9)) bus ();

  pc_sequencer #(
    .PC_W         (16),
    .OFF_W        (9),
    .STACK_DEPTH  (4),
    .RESET_VECTOR (16'h0100),
    .IRQ_VECTOR   (16'h0010)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ProgramCounter model: load, else add signed offset, else count.
  logic [15:0] r_pc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= '0;
    end else if (bus.load_enable) begin
      r_pc <= bus.load_value;
    end else if (bus.offset_enable) begin
      r_pc <= r_pc + {{7{bus.offset[8]}}, bus.offset};
    end else begin
      r_pc <= r_pc + 16'd1;
    end
  end
  assign bus.pc_in = r_pc;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] sb[$];
  logic [15:0] mon_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Fetch monitor: every accepted fetch must match the next queued address.
  always begin
    @(negedge clk);
    #2;
    if (!rst && bus.fetch_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_exp = sb.pop_front();
        chk("fetch_addr", {16'h0, bus.pc_in}, {16'h0, mon_exp});
      end
    end
  end

  // Entered just after a negedge in S_FETCH; returns just after the
  // negedge of the following S_DECODE cycle.
  task automatic do_fetch(input int stall);
    logic [15:0] a;
    int n;
    n = 0;
    #1;
    while (bus.imem_req !== 1'b1 && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("fetch_req", bus.imem_req, 1);
    a = bus.pc_in;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      #1;
      chk("stall_load_en", bus.load_enable, 1);
      chk("stall_pc", bus.pc_in, a);
    end
    bus.imem_ack = 1'b1;
    #1;
    chk("ack_fetch_valid", bus.fetch_valid, 1);
    chk("ack_load_en", bus.load_enable, 0);
    @(negedge clk);
    bus.imem_ack = 1'b0;
    #1;
    chk("fetch_valid_pulse", bus.fetch_valid, 0);
    chk("decode_pc", bus.pc_in, a + 16'd1);
  endtask

  // One DECODE cycle: drive redirect/irq/halt and queue the next fetch.
  task automatic decode(input bit bv, input br_type_e bt, input bit tk,
                        input logic [8:0] off, input logic [15:0] tgt,
                        input bit irq_v, input bit hlt,
                        input logic [15:0] exp_next, input bit exp_ack);
    bus.br_valid  = bv;
    bus.br_type   = bt;
    bus.br_taken  = tk;
    bus.br_offset = off;
    bus.br_target = tgt;
    bus.irq       = irq_v;
    bus.halt      = hlt;
    if (!hlt) sb.push_back(exp_next);
    #1;
    chk("irq_ack", bus.irq_ack, exp_ack);
    chk("decode_req", bus.imem_req, 0);
    chk("decode_halted", bus.halted, 0);
    @(negedge clk);
    bus.br_valid  = 1'b0;
    bus.br_type   = BR_REL;
    bus.br_taken  = 1'b0;
    bus.br_offset = '0;
    bus.br_target = '0;
    bus.irq       = 1'b0;
    bus.halt      = 1'b0;
  endtask

  logic [15:0] ret_exp [4];

  initial begin
    bus.imem_ack  = 1'b0;
    bus.br_valid  = 1'b0;
    bus.br_type   = BR_REL;
    bus.br_taken  = 1'b0;
    bus.br_offset = '0;
    bus.br_target = '0;
    bus.irq       = 1'b0;
    bus.halt      = 1'b0;
    rst           = 1'b1;
    ret_exp[0] = 16'h0421;
    ret_exp[1] = 16'h0411;
    ret_exp[2] = 16'h0401;
    ret_exp[3] = 16'h0302;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_load_en", bus.load_enable, 0);
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_stack_err", bus.stack_err, 0);

    // Boot: one load of the reset vector, then fetch with a 3-cycle stall.
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(16'h0100);
    #1;
    chk("boot_load_en", bus.load_enable, 1);
    chk("boot_load_val", bus.load_value, 16'h0100);
    @(negedge clk);
    do_fetch(3);

    // Relative branch taken / not taken from pc 0x0105.
    decode(1, BR_JUMP, 0, 9'h000, 16'h0104, 0, 0, 16'h0104, 0);
    do_fetch(0);
    decode(1, BR_REL, 1, 9'h1FC, 16'h0000, 0, 0, 16'h0101, 0);
    do_fetch(1);
    decode(1, BR_JUMP, 0, 9'h000, 16'h0104, 0, 0, 16'h0104, 0);
    do_fetch(0);
    decode(1, BR_REL, 0, 9'h1FC, 16'h0000, 0, 0, 16'h0105, 0);
    do_fetch(0);

    // Call from 0x0106 and return.
    decode(1, BR_CALL, 0, 9'h000, 16'h0200, 0, 0, 16'h0200, 0);
    do_fetch(2);
    decode(1, BR_RET, 0, 9'h000, 16'h0000, 0, 0, 16'h0106, 0);
    chk("call_ret_stack_err", bus.stack_err, 0);
    do_fetch(0);

    // Positive offset wrapping past the top of the address space.
    decode(1, BR_JUMP, 0, 9'h000, 16'hFFEF, 0, 0, 16'hFFEF, 0);
    do_fetch(0);
    decode(1, BR_REL, 1, 9'h0FF, 16'h0000, 0, 0, 16'h00EF, 0);
    do_fetch(0);

    // irq coincident with a jump is deferred, then taken, then masked.
    decode(1, BR_JUMP, 0, 9'h000, 16'h0300, 1, 0, 16'h0300, 0);
    do_fetch(0);
    decode(0, BR_REL, 0, 9'h000, 16'h0000, 1, 0, 16'h0010, 1);
    do_fetch(0);
    decode(0, BR_REL, 0, 9'h000, 16'h0000, 1, 0, 16'h0011, 0);
    do_fetch(0);
    decode(1, BR_RET, 0, 9'h000, 16'h0000, 0, 0, 16'h0301, 0);
    do_fetch(0);

    // Five nested calls: the fifth overflows but still reaches its target.
    for (int i = 0; i < 5; i++) begin
      decode(1, BR_CALL, 0, 9'h000, 16'h0400 + 16'(i * 16), 0, 0,
             16'h0400 + 16'(i * 16), 0);
      chk("nest_stack_err", bus.stack_err, (i == 4) ? 32'd1 : 32'd0);
      do_fetch(0);
    end
    for (int i = 0; i < 4; i++) begin
      decode(1, BR_RET, 0, 9'h000, 16'h0000, 0, 0, ret_exp[i], 0);
      do_fetch(0);
    end
    decode(0, BR_REL, 0, 9'h000, 16'h0000, 0, 0, 16'h0303, 0);

    // Reset in the middle of a fetch stall.
    #1;
    chk("pre_rst_req", bus.imem_req, 1);
    chk("pre_rst_stack_err", bus.stack_err, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_load_en", bus.load_enable, 0);
    chk("mid_rst_imem_req", bus.imem_req, 0);
    chk("mid_rst_load_val", bus.load_value, 0);
    chk("mid_rst_stack_err", bus.stack_err, 0);
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(16'h0100);
    #1;
    chk("reboot_load_val", bus.load_value, 16'h0100);
    @(negedge clk);
    do_fetch(0);

    // Return with an empty stack: error flag, PC held.
    decode(1, BR_RET, 0, 9'h000, 16'h0000, 0, 0, 16'h0101, 0);
    chk("underflow_stack_err", bus.stack_err, 1);
    do_fetch(0);

    // Halt: frozen PC, no fetches.
    decode(0, BR_REL, 0, 9'h000, 16'h0000, 0, 1, 16'h0000, 0);
    #1;
    chk("halted", bus.halted, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("halt_pc", bus.pc_in, 16'h0102);
      chk("halt_flag", bus.halted, 1);
      chk("halt_req", bus.imem_req, 0);
    end

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
